// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch / load-store memory arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam int RD_LAT_DEFAULT = 2;
    localparam int WORD_W         = 16;
endpackage

// File: rtl/mem_arb_rr.sv
// Two-input alternating-priority arbiter; on a tie the port not granted last wins.
module mem_arb_rr (
    input  logic clk,
    input  logic rstn,
    input  logic if_req,
    input  logic ls_req,
    input  logic take,
    output logic grant_ls,
    output logic last_ls
);
    always_comb grant_ls = ls_req & (~if_req | ~last_ls);

    // last_ls = 0 means fetch was granted last, so ls wins the first tie after reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_ls <= 1'b0;
        end else if (take) begin
            last_ls <= grant_ls;
        end
    end
endmodule

// File: rtl/mem_arb.sv
// Arbitrates instruction-fetch and load/store ports onto one memory controller.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_addr,
    output logic              if_ack,
    output logic [WORD_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [WORD_W-1:0] ls_addr,
    input  logic [WORD_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [WORD_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output arb_state_t        dbg_state
);
    // Handshake: a port raises req with stable op/addr/data and keeps it until a
    // one-cycle ack; req is only sampled in IDLE, and an ack-cycle req starts anew.
    localparam logic [2:0] WAIT_LAST = (RD_LAT >= 2) ? 3'(RD_LAT - 2) : 3'd0;

    arb_state_t        state, state_nx;
    logic [2:0]        cnt, cnt_nx;
    logic              cur_ls, cur_ls_nx, cur_we, cur_we_nx;
    logic [WORD_W-1:0] rd_hold, rd_hold_nx;
    logic              mem_en_nx, mem_we_nx, if_ack_nx, ls_ack_nx;
    logic [WORD_W-1:0] mem_addr_nx, mem_wdata_nx, if_rdata_nx, ls_rdata_nx;
    logic              take, grant_ls, last_ls;

    mem_arb_rr u_rr (
        .clk      (clk),
        .rstn     (rstn),
        .if_req   (if_req),
        .ls_req   (ls_req),
        .take     (take),
        .grant_ls (grant_ls),
        .last_ls  (last_ls)
    );

    assign dbg_state = state;

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        cur_ls_nx    = cur_ls;
        cur_we_nx    = cur_we;
        rd_hold_nx   = rd_hold;
        mem_en_nx    = mem_en;
        mem_we_nx    = 1'b0;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        if_ack_nx    = 1'b0;
        ls_ack_nx    = 1'b0;
        if_rdata_nx  = if_rdata;
        ls_rdata_nx  = ls_rdata;
        take         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (if_req || ls_req) begin
                    take         = 1'b1;
                    state_nx     = ST_ISSUE;
                    cnt_nx       = 3'd0;
                    cur_ls_nx    = grant_ls;
                    cur_we_nx    = grant_ls & ls_we;
                    mem_en_nx    = 1'b1;
                    mem_we_nx    = grant_ls & ls_we;
                    mem_addr_nx  = grant_ls ? ls_addr : if_addr;
                    mem_wdata_nx = grant_ls ? ls_wdata : mem_wdata;
                end
            end
            ST_ISSUE: begin
                if (cur_we) begin
                    mem_en_nx = 1'b0;
                    state_nx  = ST_DONE;
                end else if (RD_LAT == 1) begin
                    rd_hold_nx = mem_rdata;
                    mem_en_nx  = 1'b0;
                    state_nx   = ST_DONE;
                end else begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // read data is taken on the last edge with mem_en still high
                if (cnt == WAIT_LAST) begin
                    rd_hold_nx = mem_rdata;
                    mem_en_nx  = 1'b0;
                    state_nx   = ST_DONE;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            ST_DONE: begin
                state_nx  = ST_IDLE;
                if_ack_nx = ~cur_ls;
                ls_ack_nx = cur_ls;
                if (!cur_we) begin
                    if (cur_ls) ls_rdata_nx = rd_hold;
                    else        if_rdata_nx = rd_hold;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            cnt       <= 3'd0;
            cur_ls    <= 1'b0;
            cur_we    <= 1'b0;
            rd_hold   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            ls_ack    <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            cur_ls    <= cur_ls_nx;
            cur_we    <= cur_we_nx;
            rd_hold   <= rd_hold_nx;
            mem_en    <= mem_en_nx;
            mem_we    <= mem_we_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            if_ack    <= if_ack_nx;
            ls_ack    <= ls_ack_nx;
            if_rdata  <= if_rdata_nx;
            ls_rdata  <= ls_rdata_nx;
        end
    end
endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: transaction-level reference model plus directed latency/reset cases.
module tb_mem_arb;
    import mem_arb_pkg::*;

    localparam int L_MAIN = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn = 1'b1;
    logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
    logic [15:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
    logic        if_ack, ls_ack, mem_en, mem_we;
    logic [15:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
    arb_state_t  dbg_state;

    logic        lat_req = 1'b0;
    logic [15:0] lat_addr = '0;
    logic        l1_if_ack, l1_ls_ack, l1_en, l1_we, l4_if_ack, l4_ls_ack, l4_en, l4_we;
    logic [15:0] l1_if_rdata, l1_ls_rdata, l1_addr, l1_wdata, l1_rdata;
    logic [15:0] l4_if_rdata, l4_ls_rdata, l4_addr, l4_wdata, l4_rdata;
    arb_state_t  l1_state, l4_state;

    mem_arb #(.RD_LAT(L_MAIN)) u_dut (
        .clk(clk), .rstn(rstn), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_rdata(if_rdata), .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_rdata(ls_rdata), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    mem_arb #(.RD_LAT(1)) u_l1 (
        .clk(clk), .rstn(rstn), .if_req(lat_req), .if_addr(lat_addr), .if_ack(l1_if_ack),
        .if_rdata(l1_if_rdata), .ls_req(1'b0), .ls_we(1'b0), .ls_addr(16'h0),
        .ls_wdata(16'h0), .ls_ack(l1_ls_ack), .ls_rdata(l1_ls_rdata), .mem_en(l1_en),
        .mem_we(l1_we), .mem_addr(l1_addr), .mem_wdata(l1_wdata),
        .mem_rdata(l1_rdata), .dbg_state(l1_state)
    );

    mem_arb #(.RD_LAT(4)) u_l4 (
        .clk(clk), .rstn(rstn), .if_req(lat_req), .if_addr(lat_addr), .if_ack(l4_if_ack),
        .if_rdata(l4_if_rdata), .ls_req(1'b0), .ls_we(1'b0), .ls_addr(16'h0),
        .ls_wdata(16'h0), .ls_ack(l4_ls_ack), .ls_rdata(l4_ls_rdata), .mem_en(l4_en),
        .mem_we(l4_we), .mem_addr(l4_addr), .mem_wdata(l4_wdata),
        .mem_rdata(l4_rdata), .dbg_state(l4_state)
    );

    int n_pass = 0, n_total = 0;
    int cyc = 0;
    int en_cycles = 0, we_cycles = 0, if_acks = 0, ls_acks = 0, both_acks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] init_word(input int a);
        case (a)
            'h0040:  return 16'h1234;
            'h0200:  return 16'h5555;
            default: return 16'(a) ^ 16'hA5A5;
        endcase
    endfunction

    // Memory environment: data becomes valid once mem_en has been high RD_LAT cycles;
    // wrong data before that, and a DEAD marker stands in for high-Z while disabled.
    logic [15:0] mem [0:65535];
    int en_cnt, l4_cnt;
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] <= init_word(i);
        en_cnt <= 0;
        l4_cnt <= 0;
        forever begin
            @(posedge clk);
            if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
            en_cnt <= mem_en ? en_cnt + 1 : 0;
            l4_cnt <= l4_en ? l4_cnt + 1 : 0;
        end
    end
    assign mem_rdata = !mem_en ? 16'hDEAD : (en_cnt >= L_MAIN - 1) ? mem[mem_addr] : ~mem[mem_addr];
    assign l1_rdata  = !l1_en ? 16'hDEAD : mem[l1_addr];
    assign l4_rdata  = !l4_en ? 16'hDEAD : (l4_cnt >= 3) ? mem[l4_addr] : ~mem[l4_addr];

    // Reference model: one transaction at a time, timeline counted from the sample edge.
    logic [15:0] shadow [0:65535];
    bit          m_busy = 0, m_ls = 0, m_store = 0, m_last_ls = 0;
    int          m_t = 0;
    logic [15:0] m_addr = '0, m_wdata = '0, m_rdv = '0, exp_if_rd = '0, exp_ls_rd = '0;

    function automatic int ack_t();
        return m_store ? 3 : L_MAIN + 2;
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) shadow[i] = init_word(i);
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                m_busy = 0; m_t = 0; m_last_ls = 0; exp_if_rd = '0; exp_ls_rd = '0;
            end else if (m_busy && m_t < ack_t()) begin
                m_t++;
                if (m_t == ack_t() && !m_store) begin
                    if (m_ls) exp_ls_rd = m_rdv;
                    else      exp_if_rd = m_rdv;
                end
            end else if (if_req || ls_req) begin
                if (if_req && ls_req) m_ls = !m_last_ls;
                else                  m_ls = ls_req;
                m_last_ls = m_ls;
                m_store   = m_ls && ls_we;
                m_addr    = m_ls ? ls_addr : if_addr;
                m_wdata   = ls_wdata;
                m_rdv     = shadow[m_addr];
                if (m_store) shadow[m_addr] = m_wdata;
                m_busy = 1;
                m_t    = 1;
            end else begin
                m_busy = 0;
                m_t    = 0;
            end
        end
    end

    // Per-cycle comparison against the model, plus activity counters.
    initial begin
        bit e_en, e_we, e_ack;
        forever begin
            @(negedge clk);
            e_en  = m_busy && (m_t <= (m_store ? 1 : L_MAIN));
            e_we  = m_busy && m_store && (m_t == 1);
            e_ack = m_busy && (m_t == ack_t());
            chk("mem_en", 32'(mem_en), 32'(e_en));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            if (e_en) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            chk("if_ack", 32'(if_ack), 32'(e_ack && !m_ls));
            chk("ls_ack", 32'(ls_ack), 32'(e_ack && m_ls));
            chk("if_rdata", 32'(if_rdata), 32'(exp_if_rd));
            chk("ls_rdata", 32'(ls_rdata), 32'(exp_ls_rd));
            en_cycles += int'(mem_en);
            we_cycles += int'(mem_we);
            if_acks   += int'(if_ack);
            ls_acks   += int'(ls_ack);
            both_acks += int'(if_ack && ls_ack);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_txn(input bit use_ls, input bit we, input logic [15:0] addr,
                          input logic [15:0] wd, output int lat);
        int c0;
        step();
        if (use_ls) begin
            ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        @(posedge clk);
        #1;
        c0  = cyc;
        lat = -1;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            step();
            if ((use_ls && ls_ack) || (!use_ls && if_ack)) lat = cyc - c0 + 1;
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        if (lat < 0) chk("txn_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_reset();
        step();
        rstn = 1'b0;
        repeat (2) step();
        rstn = 1'b1;
        step();
    endtask

    initial begin
        int lat, e0, w0, a0, b0, k, a1, a4, c0;
        logic [15:0] r1, r4;
        logic [3:0]  order;

        #1 rstn = 1'b0;
        repeat (3) step();
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_acks", 32'({if_ack, ls_ack}), 32'd0);
        chk("rst_rdata", 32'({if_rdata, ls_rdata}), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rstn = 1'b1;
        step();

        // Fetch of 0x0040 holding 0x1234.
        e0 = en_cycles; a0 = if_acks;
        do_txn(1'b0, 1'b0, 16'h0040, 16'h0, lat);
        repeat (2) step();
        chk("fetch_lat", 32'(lat), 32'd4);
        chk("fetch_data", 32'(if_rdata), 32'h1234);
        chk("fetch_en_cycles", 32'(en_cycles - e0), 32'd2);
        chk("fetch_acks", 32'(if_acks - a0), 32'd1);

        // Store then load back the same word.
        w0 = we_cycles; b0 = ls_acks;
        do_txn(1'b1, 1'b1, 16'h0100, 16'hBEEF, lat);
        chk("store_lat", 32'(lat), 32'd3);
        do_txn(1'b1, 1'b0, 16'h0100, 16'h0, lat);
        repeat (2) step();
        chk("load_lat", 32'(lat), 32'd4);
        chk("load_data", 32'(ls_rdata), 32'hBEEF);
        chk("store_we_cycles", 32'(we_cycles - w0), 32'd1);
        chk("ls_acks", 32'(ls_acks - b0), 32'd2);

        // A store must leave both read-data registers alone.
        do_txn(1'b0, 1'b0, 16'h0200, 16'h0, lat);
        chk("fetch_5555", 32'(if_rdata), 32'h5555);
        do_txn(1'b1, 1'b1, 16'h0300, 16'h1357, lat);
        repeat (2) step();
        chk("store_keeps_if", 32'(if_rdata), 32'h5555);
        chk("store_keeps_ls", 32'(ls_rdata), 32'hBEEF);

        // Both ports held: grants alternate starting with ls.
        pulse_reset();
        if_req = 1'b1; if_addr = 16'h0040;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0200;
        k = 0; order = '0;
        for (int i = 0; i < 60 && k < 4; i++) begin
            step();
            if (if_ack && ls_ack) chk("tie_simul_ack", 32'd1, 32'd0);
            if (if_ack || ls_ack) begin
                order[3-k] = ls_ack;
                k++;
            end
        end
        if_req = 1'b0; ls_req = 1'b0;
        chk("tie_count", 32'(k), 32'd4);
        chk("tie_order", 32'(order), 32'b1010);
        repeat (4) step();

        // Reset during WAIT aborts the fetch with no ack.
        step();
        if_req = 1'b1; if_addr = 16'h0040;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("wait_en_high", 32'(mem_en), 32'd1);
        #1 rstn = 1'b0;
        #1;
        chk("abort_mem_en", 32'(mem_en), 32'd0);
        chk("abort_addr", 32'(mem_addr), 32'd0);
        chk("abort_rdata", 32'({if_rdata, ls_rdata}), 32'd0);
        if_req = 1'b0;
        a0 = if_acks; b0 = ls_acks;
        repeat (3) step();
        rstn = 1'b1;
        repeat (3) step();
        chk("abort_no_ack", 32'((if_acks - a0) + (ls_acks - b0)), 32'd0);
        do_txn(1'b0, 1'b0, 16'h0040, 16'h0, lat);
        repeat (2) step();
        chk("after_abort_lat", 32'(lat), 32'd4);
        chk("after_abort_data", 32'(if_rdata), 32'h1234);

        // Fetch latency at RD_LAT = 1 and 4.
        step();
        lat_req = 1'b1; lat_addr = 16'h0200;
        @(posedge clk);
        #1;
        c0 = cyc; a1 = -1; a4 = -1; r1 = '0; r4 = '0;
        for (int i = 0; i < 20 && (a1 < 0 || a4 < 0); i++) begin
            step();
            if (l1_if_ack && a1 < 0) begin a1 = cyc - c0 + 1; r1 = l1_if_rdata; end
            if (l4_if_ack && a4 < 0) begin a4 = cyc - c0 + 1; r4 = l4_if_rdata; end
        end
        lat_req = 1'b0;
        chk("lat1_ack_cycle", 32'(a1), 32'd3);
        chk("lat4_ack_cycle", 32'(a4), 32'd6);
        chk("lat1_data", 32'(r1), 32'h5555);
        chk("lat4_data", 32'(r4), 32'h5555);
        repeat (10) step();

        // Random traffic on both ports, checked cycle by cycle against the model.
        for (int i = 0; i < 2500; i++) begin
            step();
            if (if_req) begin
                if (if_ack) begin
                    if ($urandom_range(0, 3) != 0) if_req = 1'b0;
                end else if ($urandom_range(0, 29) == 0) begin
                    if_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = 16'($urandom_range(0, 31));
            end
            if (ls_req) begin
                if (ls_ack) begin
                    if ($urandom_range(0, 3) != 0) ls_req = 1'b0;
                end else if ($urandom_range(0, 29) == 0) begin
                    ls_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                ls_req   = 1'b1;
                ls_we    = 1'($urandom_range(0, 1));
                ls_addr  = 16'($urandom_range(0, 31));
                ls_wdata = 16'($urandom_range(0, 65535));
            end
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        repeat (12) step();
        chk("never_simul_ack", 32'(both_acks), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
